// File: rtl/regfile_we_scoreboard.sv
// regfile_we_scoreboard: pending-write scoreboard with hazard stall and registered one-hot write enable
module regfile_we_scoreboard #(
    parameter int AW         = 5,
    parameter int ZERO_REG   = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_addr,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_addr,
    input  logic [AW-1:0]     rs_addr,
    input  logic [AW-1:0]     rt_addr,
    output logic              stall,
    output logic [2**AW-1:0]  we_out,
    output logic [2**AW-1:0]  busy,
    output logic [AW:0]       busy_cnt
);
    localparam int N = 2**AW;
    localparam bit ZR = ZERO_REG != 0;
    localparam logic [N-1:0] WE_IDLE = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
    logic [N-1:0] r_busy, r_we, w_clr_mask, w_set_mask;
    logic [AW:0]  r_cnt;
    logic         w_eff_clr, w_set, w_set_new, w_clr_real, w_hz_rs, w_hz_rt;
    assign w_eff_clr   = wb_valid && !(ZR && wb_addr == '0);
    assign w_clr_mask  = w_eff_clr ? N'(1) << wb_addr : '0;
    assign issue_ready = rst || !r_busy[issue_addr] || w_clr_mask[issue_addr];
    assign w_set       = issue_valid && issue_ready && !rst && !(ZR && issue_addr == '0);
    assign w_set_mask  = w_set ? N'(1) << issue_addr : '0;
    // Count only real 0->1 and 1->0 transitions; a set racing a clear on one entry nets to zero.
    assign w_set_new   = w_set && !r_busy[issue_addr];
    assign w_clr_real  = w_eff_clr && r_busy[wb_addr] && !w_set_mask[wb_addr];
    assign w_hz_rs     = r_busy[rs_addr] && !w_clr_mask[rs_addr] && !(ZR && rs_addr == '0);
    assign w_hz_rt     = r_busy[rt_addr] && !w_clr_mask[rt_addr] && !(ZR && rt_addr == '0);
    assign stall       = !rst && (w_hz_rs || w_hz_rt);
    assign we_out      = r_we;
    assign busy        = r_busy;
    assign busy_cnt    = r_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
            r_we   <= WE_IDLE;
        end else begin
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
            r_cnt  <= r_cnt + (AW+1)'(w_set_new) - (AW+1)'(w_clr_real);
            r_we   <= WE_IDLE ^ w_clr_mask;
        end
    end
endmodule

// File: doc/regfile_we_scoreboard.md
REGFILE_WE_SCOREBOARD -- requirements
Module: regfile_we_scoreboard

Interface
REQ-001 The block SHALL have parameter AW, default 5, meaning register address width; N = 2**AW entries.
REQ-002 The block SHALL have parameter ZERO_REG, default 1, meaning 1 = entry 0 is hard-wired, never enabled and never busy.
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1, meaning 1 = we_out asserted level is 0, 0 = asserted level is 1.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports ordered as in REQ-005 to REQ-017.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 issue_valid  input  1  request to mark issue_addr as pending writer.
REQ-008 issue_addr  input  AW  destination register of the issuing instruction.
REQ-009 issue_ready  output  1  issue will be accepted this cycle.
REQ-010 wb_valid  input  1  writeback strobe.
REQ-011 wb_addr  input  AW  writeback destination register.
REQ-012 rs_addr  input  AW  first source register to hazard-check.
REQ-013 rt_addr  input  AW  second source register to hazard-check.
REQ-014 stall  output  1  a source register has an outstanding write.
REQ-015 we_out  output  N  registered decoded write enable, one bit per entry.
REQ-016 busy  output  N  per-entry pending-write flags.
REQ-017 busy_cnt  output  AW+1  number of set bits in busy.

Function
REQ-018 The block SHALL compute eff_clr = wb_valid AND NOT (ZERO_REG AND wb_addr==0).
REQ-019 The block SHALL drive issue_ready = NOT busy[issue_addr] OR (eff_clr AND wb_addr==issue_addr), combinationally.
REQ-020 The block SHALL accept an issue when issue_valid AND issue_ready; an issue with issue_ready=0 SHALL leave all state unchanged.
REQ-021 An accepted issue SHALL set busy[issue_addr] at the next edge, except that an issue to entry 0 with ZERO_REG=1 SHALL be accepted with no state change.
REQ-022 eff_clr SHALL clear busy[wb_addr] at the next edge; a writeback to a non-busy entry SHALL still produce we_out but SHALL NOT change busy or busy_cnt.
REQ-023 When an accepted issue and eff_clr target the same entry in the same cycle, the set SHALL win and busy SHALL remain 1.
REQ-024 The block SHALL update busy_cnt by +1, -1 or 0 in step with busy, so that busy_cnt always equals popcount(busy), with no wrap (maximum N-ZERO_REG).
REQ-025 The block SHALL drive stall = hz(rs_addr) OR hz(rt_addr), combinationally, where hz(a) = busy[a] AND NOT (eff_clr AND wb_addr==a) AND NOT (ZERO_REG AND a==0).
REQ-026 One cycle after wb_valid, we_out SHALL have only bit wb_addr at the asserted level; all other bits SHALL be at the inactive level.
REQ-027 With ZERO_REG=1 and wb_addr==0, all we_out bits SHALL be inactive; in every cycle with no wb_valid, all we_out bits SHALL be inactive.
REQ-028 At most one we_out bit SHALL be asserted in any cycle.
REQ-029 Latency SHALL be: busy, busy_cnt and we_out change 1 cycle after the stimulus; issue_ready and stall have 0 cycles of latency.

Reset
REQ-030 While rst=1 at an edge, the block SHALL clear busy and busy_cnt to 0 and set every we_out bit to the inactive level (all ones when ACTIVE_LOW=1), ignoring issue and writeback inputs.
REQ-031 A reset applied mid-operation SHALL discard all pending flags with no we_out pulse.
REQ-032 During reset and in the cycle after it, stall SHALL be 0 and issue_ready SHALL be 1.

Verification
REQ-033 Reset check: hold rst=1 for 2 cycles with issue_valid=1 and wb_valid=1 -> busy=0, busy_cnt=0, we_out=32'hFFFF_FFFF.
REQ-034 Decode sweep: apply wb_valid with wb_addr 0..31 in successive cycles -> we_out=32'hFFFF_FFFF for address 0, then ~(1<<k) one cycle after each address k.
REQ-035 Hazard: issue addr 7; next cycle rs_addr=7 -> stall=1, busy_cnt=1; apply wb 7 with rs_addr=7 in the same cycle -> stall=0 that cycle, then busy[7]=0 and we_out=32'hFFFF_FF7F.
REQ-036 Collisions: with busy[9]=1, issue 9 together with wb 9 -> issue_ready=1, busy[9] stays 1, busy_cnt unchanged; then issue 9 alone -> issue_ready=0 and state unchanged.
REQ-037 Zero entry: issue 0 and rs_addr=0 -> busy[0]=0, stall=0, busy_cnt=0; fill entries 1..31 -> busy_cnt=31, no wrap.
REQ-038 Mid-operation reset: with 5 entries busy, assert rst together with wb 3 -> next cycle busy=0, busy_cnt=0, we_out all ones.
